reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated scoreboard. It is the next-generation successor to the single-write, dual-read RV32I register bank.
- Provides NRP combinational read ports and NWP synchronous write ports.
- Write-to-read bypass is selectable.
- Per-register busy bits support a pipelined or dual-issue core: decode marks a destination busy, writeback clears it.
- Sits between the decode/issue stage and the writeback stage of the core datapath.

---
 rtl/reg_file_mp_if.sv | 27 ++
 rtl/reg_file_mp.sv | 75 +++++++
 tb/tb_reg_file_mp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bundle of read, write and issue signals between the issue/writeback stages and reg_file_mp.
// The master side drives addresses, write data and issue strobes; the slave side returns read data and busy bits.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2,
  parameter int NWP  = 1
);
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   waddr;
  logic [NWP*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_rd,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_rd,
    output rdata, rbusy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero; addresses at or above NREGS read as zero and are never written.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int NWP    = 1,
  parameter int BYPASS = 1
) (
  input logic          clock,
  input logic          reset,
  reg_file_mp_if.slave rf
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Ascending port order lets the highest-numbered write port win; issue is applied last so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int w = 0; w < NWP; w++) begin
        if (rf.we[w] && (rf.waddr[w*AW +: AW] == AW'(r))) begin
          regs_d[r] = rf.wdata[w*XLEN +: XLEN];
          busy_d[r] = 1'b0;
        end
      end
      if (rf.iss_valid && (rf.iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Only addresses 1..NREGS-1 ever match, so x0 and out-of-range reads fall through to zero.
  always_comb begin
    rf.rdata = '0;
    rf.rbusy = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rf.raddr[p*AW +: AW] == AW'(r)) begin
          rf.rdata[p*XLEN +: XLEN] = regs_q[r];
          rf.rbusy[p]              = busy_q[r];
          if (BYPASS != 0) begin
            for (int w = 0; w < NWP; w++) begin
              if (rf.we[w] && (rf.waddr[w*AW +: AW] == AW'(r))) begin
                rf.rdata[p*XLEN +: XLEN] = rf.wdata[w*XLEN +: XLEN];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing dual-write instance with 28 registers and a non-bypassing single-write
// instance with 32 registers share one stimulus stream and are compared against array-based reference models.
module tb_reg_file_mp;

  localparam int NA = 28;
  localparam int NB = 32;

  logic clock;
  logic reset_s;

  logic [4:0]  ra [2];
  logic [1:0]  we_s;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        iss_v;
  logic [4:0]  iss_r;

  logic [31:0] mem_a [32];
  logic        busy_a [32];
  logic [31:0] mem_b [32];
  logic        busy_b [32];

  int errors = 0;
  int checks = 0;

  reg_file_mp_if #(.XLEN(32), .AW(5), .NRP(2), .NWP(2)) ifa ();
  reg_file_mp_if #(.XLEN(32), .AW(5), .NRP(2), .NWP(1)) ifb ();

  assign ifa.raddr     = {ra[1], ra[0]};
  assign ifa.we        = we_s;
  assign ifa.waddr     = {wa[1], wa[0]};
  assign ifa.wdata     = {wd[1], wd[0]};
  assign ifa.iss_valid = iss_v;
  assign ifa.iss_rd    = iss_r;

  assign ifb.raddr     = {ra[1], ra[0]};
  assign ifb.we        = we_s[0];
  assign ifb.waddr     = wa[0];
  assign ifb.wdata     = wd[0];
  assign ifb.iss_valid = iss_v;
  assign ifb.iss_rd    = iss_r;

  reg_file_mp #(.XLEN(32), .NREGS(NA), .AW(5), .NRP(2), .NWP(2), .BYPASS(1)) dut_a (
    .clock (clock),
    .reset (reset_s),
    .rf    (ifa.slave)
  );

  reg_file_mp #(.XLEN(32), .NREGS(NB), .AW(5), .NRP(2), .NWP(1), .BYPASS(0)) dut_b (
    .clock (clock),
    .reset (reset_s),
    .rf    (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Architectural view: a read of a valid register sees the latest enabled write this cycle (bypass) or storage.
  function automatic logic [31:0] exp_a_data(logic [4:0] a);
    logic [31:0] v;
    if (a == 0 || int'(a) >= NA) return 32'h0;
    v = mem_a[a];
    if (we_s[0] && wa[0] == a) v = wd[0];
    if (we_s[1] && wa[1] == a) v = wd[1];
    return v;
  endfunction

  function automatic logic [31:0] exp_b_data(logic [4:0] a);
    if (a == 0) return 32'h0;
    return mem_b[a];
  endfunction

  function automatic logic exp_a_busy(logic [4:0] a);
    if (a == 0 || int'(a) >= NA) return 1'b0;
    return busy_a[a];
  endfunction

  function automatic logic exp_b_busy(logic [4:0] a);
    if (a == 0) return 1'b0;
    return busy_b[a];
  endfunction

  task automatic model_edge();
    if (!reset_s) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = 0; busy_a[i] = 0; mem_b[i] = 0; busy_b[i] = 0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (we_s[w] && wa[w] != 0 && int'(wa[w]) < NA) mem_a[wa[w]] = wd[w];
        if (we_s[w] && int'(wa[w]) < NA) busy_a[wa[w]] = 1'b0;
      end
      if (iss_v && iss_r != 0 && int'(iss_r) < NA) busy_a[iss_r] = 1'b1;
      if (we_s[0] && wa[0] != 0) mem_b[wa[0]] = wd[0];
      if (we_s[0]) busy_b[wa[0]] = 1'b0;
      if (iss_v && iss_r != 0) busy_b[iss_r] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    for (int p = 0; p < 2; p++) begin
      cmp($sformatf("A.rdata%0d@x%0d", p, ra[p]), ifa.rdata[p*32 +: 32], exp_a_data(ra[p]));
      cmp($sformatf("A.rbusy%0d@x%0d", p, ra[p]), {31'h0, ifa.rbusy[p]}, {31'h0, exp_a_busy(ra[p])});
      cmp($sformatf("B.rdata%0d@x%0d", p, ra[p]), ifb.rdata[p*32 +: 32], exp_b_data(ra[p]));
      cmp($sformatf("B.rbusy%0d@x%0d", p, ra[p]), {31'h0, ifb.rbusy[p]}, {31'h0, exp_b_busy(ra[p])});
    end
  endtask

  task automatic idle();
    we_s = 2'b00; iss_v = 1'b0; iss_r = 5'd0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 0; busy_a[i] = 0; mem_b[i] = 0; busy_b[i] = 0;
    end
    reset_s = 1'b0;
    ra[0] = 0; ra[1] = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    idle();
    tick();
    tick();

    // Reset state, including an address that is out of range for the 28-register instance
    reset_s = 1'b1;
    ra[0] = 5'd5; ra[1] = 5'd31;
    check_all();

    // Write x5, then read it back after the edge
    we_s = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    check_all();
    tick();
    idle();
    check_all();

    // Writes to x0 are dropped, bypass included
    we_s = 2'b01; wa[0] = 5'd0; wd[0] = 32'h12345678; ra[0] = 5'd0;
    check_all();
    tick();
    idle();
    check_all();

    // Bypass versus stored value on x7
    we_s = 2'b01; wa[0] = 5'd7; wd[0] = 32'h1;
    tick();
    idle();
    we_s = 2'b01; wa[0] = 5'd7; wd[0] = 32'hA5A5A5A5; ra[0] = 5'd7;
    check_all();
    tick();
    idle();
    check_all();

    // Two ports hitting x9: the higher port wins
    we_s = 2'b11; wa[0] = 5'd9; wd[0] = 32'h11; wa[1] = 5'd9; wd[1] = 32'h22; ra[0] = 5'd9;
    check_all();
    tick();
    idle();
    check_all();

    // Scoreboard: issue, writeback, then simultaneous issue and writeback
    ra[0] = 5'd3; ra[1] = 5'd9;
    iss_v = 1'b1; iss_r = 5'd3;
    check_all();
    tick();
    idle();
    check_all();
    we_s = 2'b01; wa[0] = 5'd3; wd[0] = 32'h77;
    check_all();
    tick();
    idle();
    check_all();
    we_s = 2'b01; wa[0] = 5'd3; wd[0] = 32'h88; iss_v = 1'b1; iss_r = 5'd3;
    tick();
    idle();
    check_all();

    // Issue of x0 never marks busy
    iss_v = 1'b1; iss_r = 5'd0; ra[0] = 5'd0;
    tick();
    idle();
    check_all();

    // Reset with a pending write and a busy register
    we_s = 2'b01; wa[0] = 5'd4; wd[0] = 32'h55; iss_v = 1'b1; iss_r = 5'd4; ra[0] = 5'd4;
    tick();
    idle();
    check_all();
    reset_s = 1'b0; we_s = 2'b01; wa[0] = 5'd4; wd[0] = 32'h99;
    tick();
    reset_s = 1'b1;
    idle();
    check_all();

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      reset_s = ($urandom_range(0, 39) != 0);
      ra[0] = rnd_addr(); ra[1] = rnd_addr();
      we_s = 2'($urandom_range(0, 3));
      wa[0] = rnd_addr(); wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : rnd_addr();
      wd[0] = $urandom; wd[1] = $urandom;
      iss_v = ($urandom_range(0, 1) == 1);
      iss_r = ($urandom_range(0, 3) == 0) ? wa[0] : rnd_addr();
      check_all();
      tick();
    end
    reset_s = 1'b1;
    idle();
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
